key_sequencer: RTL and testbench

KEY_SEQUENCER -- requirements
Module: key_sequencer

---
 rtl/key_sequencer.sv | 132 +++++++++++++
 tb/tb_key_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/key_sequencer.sv
// key_sequencer: types a 0..9999 value as a timed keypad sequence (digits, optional terminator).
module key_sequencer #(
  parameter int         PRESS_CYC = 50000,
  parameter int         GAP_CYC   = 50000,
  parameter int         TERM_EN   = 1,
  parameter logic [3:0] TERM_KEY  = 4'd14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] value,
  input  logic        abort,
  output logic [3:0]  keyword,
  output logic [1:0]  flag_pressed,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int MX = PRESS_CYC > GAP_CYC ? PRESS_CYC : GAP_CYC;
  localparam int CW = $clog2(MX + 1);
  localparam logic [CW-1:0] P_LD = CW'(PRESS_CYC - 1);
  localparam logic [CW-1:0] G_LD = CW'(GAP_CYC - 1);
  typedef enum logic [2:0] {IDLE, CONV, PRESS, GAP, FIN} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    conv_cnt;
  logic [15:0]   bcd;
  logic [13:0]   sh;
  logic [15:0]   kq;
  logic [2:0]    left;
  logic [11:0]   adj;
  logic [2:0]    th;
  logic [15:0]   bcd_n;
  logic [15:0]   shl;
  logic [19:0]   list;
  logic [1:0]    lead;
  logic [2:0]    ndig;
  logic [2:0]    len;
  // One double-dabble step; the key list is built from the post-step digits so the
  // first key can be loaded on the same edge that finishes the conversion.
  always_comb begin
    for (int i = 0; i < 3; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    th = bcd[14:12] + (bcd[15:12] >= 4'd5 ? 3'd3 : 3'd0);
    bcd_n = {th, adj, sh[13]};
    lead = 2'd3;
    for (int i = 3; i >= 0; i--)
      if (bcd_n[15-4*i -: 4] != 4'd0) lead = 2'(i);
    ndig = 3'd4 - {1'b0, lead};
    shl = bcd_n << {lead, 2'b00};
    list = {shl, 4'hF};
    for (int k = 0; k < 5; k++)
      list[19-4*k -: 4] = 3'(k) < ndig ? list[19-4*k -: 4] :
                          (3'(k) == ndig && TERM_EN != 0) ? TERM_KEY : 4'hF;
    len = ndig + (TERM_EN != 0 ? 3'd1 : 3'd0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      keyword <= 4'hF;
      flag_pressed <= 2'b00;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      cnt <= '0;
      conv_cnt <= '0;
      bcd <= '0;
      sh <= '0;
      kq <= '1;
      left <= '0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      if (abort && state != IDLE) begin
        state <= IDLE;
        keyword <= 4'hF;
        flag_pressed <= 2'b00;
        busy <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            if (value > 14'd9999) err <= 1'b1;
            else begin
              state <= CONV;
              busy <= 1'b1;
              sh <= value;
              bcd <= '0;
              conv_cnt <= '0;
            end
          end
          CONV: begin
            bcd <= bcd_n;
            sh <= {sh[12:0], 1'b0};
            conv_cnt <= conv_cnt + 4'd1;
            if (conv_cnt == 4'd13) begin
              state <= PRESS;
              keyword <= list[19:16];
              flag_pressed <= 2'b01;
              kq <= list[15:0];
              left <= len - 3'd1;
              cnt <= P_LD;
            end
          end
          PRESS: if (cnt == '0) begin
            state <= GAP;
            keyword <= 4'hF;
            flag_pressed <= 2'b00;
            cnt <= G_LD;
          end else cnt <= cnt - 1'b1;
          GAP: if (cnt == '0) begin
            if (left == 3'd0) begin
              state <= FIN;
              done <= 1'b1;
            end else begin
              state <= PRESS;
              keyword <= kq[15:12];
              flag_pressed <= 2'b01;
              kq <= {kq[11:0], 4'hF};
              left <= left - 3'd1;
              cnt <= P_LD;
            end
          end else cnt <= cnt - 1'b1;
          FIN: begin
            state <= IDLE;
            busy <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_key_sequencer.sv
// tb_key_sequencer: per-cycle check of key_sequencer against a queue-based output model.
module tb_key_sequencer;
  localparam int P = 4, G = 2;
  logic clk = 0, rst = 1, start = 0, abort = 0;
  logic [13:0] value = '0;
  logic [3:0] keyword;
  logic [1:0] flag_pressed;
  logic busy, done, err;
  typedef struct packed {logic [3:0] kw; logic [1:0] fp; logic busy; logic done; logic err;} o_t;
  localparam o_t IDL = '{4'hF, 2'b00, 1'b0, 1'b0, 1'b0};
  o_t exp_o = IDL, got, q[$];
  int vectors = 0, fails = 0, done_cnt = 0, busy_cnt = 0;
  logic [3:0] obs[$];
  logic prev_fp = 0;

  key_sequencer #(.PRESS_CYC(P), .GAP_CYC(G), .TERM_EN(1), .TERM_KEY(4'd14)) dut (
    .clk(clk), .rst(rst), .start(start), .value(value), .abort(abort),
    .keyword(keyword), .flag_pressed(flag_pressed), .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;

  // Expected output trace of a whole accepted sequence, from the first busy cycle to FIN.
  function automatic void push_seq(int v);
    int keys[$];
    if (v == 0) keys.push_back(0);
    else while (v > 0) begin keys.push_front(v % 10); v = v / 10; end
    keys.push_back(14);
    repeat (14) q.push_back('{4'hF, 2'b00, 1'b1, 1'b0, 1'b0});
    foreach (keys[i]) begin
      repeat (P) q.push_back('{4'(keys[i]), 2'b01, 1'b1, 1'b0, 1'b0});
      repeat (G) q.push_back('{4'hF, 2'b00, 1'b1, 1'b0, 1'b0});
    end
    q.push_back('{4'hF, 2'b00, 1'b1, 1'b1, 1'b0});
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin q.delete(); exp_o = IDL; end
    else if (abort && exp_o.busy) begin q.delete(); exp_o = IDL; end
    else if (!exp_o.busy) begin
      exp_o = IDL;
      if (start) begin
        if (value > 14'd9999) exp_o.err = 1'b1;
        else begin push_seq(int'(value)); exp_o = q.pop_front(); end
      end
    end else exp_o = q.size() > 0 ? q.pop_front() : IDL;
    #1;
    got = {keyword, flag_pressed, busy, done, err};
    vectors++;
    if (got !== exp_o) begin
      fails++;
      $display("FAIL cycle_check t=%0t got kw=%h fp=%b busy=%b done=%b err=%b exp kw=%h fp=%b busy=%b done=%b err=%b",
               $time, got.kw, got.fp, got.busy, got.done, got.err,
               exp_o.kw, exp_o.fp, exp_o.busy, exp_o.done, exp_o.err);
    end
    if (flag_pressed == 2'b01 && !prev_fp) obs.push_back(keyword);
    prev_fp = flag_pressed[0];
    if (done) done_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic chk(input string name, input int g, input int e);
    vectors++;
    if (g !== e) begin fails++; $display("FAIL %s got=%0d exp=%0d", name, g, e); end
  endtask

  task automatic clr();
    obs.delete(); done_cnt = 0; busy_cnt = 0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy && t < 400) begin @(negedge clk); t++; end
    chk({name, "_timeout"}, int'(busy), 0);
  endtask

  task automatic run(input int v, input logic [19:0] lit, input int n);
    clr();
    @(negedge clk); start = 1; value = 14'(v);
    @(negedge clk); start = 0;
    chk("busy_rise", int'(busy), 1);
    wait_idle("run");
    chk("key_count", obs.size(), n);
    for (int i = 0; i < n && i < obs.size(); i++) chk("key_val", int'(obs[i]), int'(lit[19-4*i -: 4]));
    chk("done_count", done_cnt, 1);
    chk("busy_cycles", busy_cnt, 14 + 6 * n + 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    chk("reset_kw", int'(keyword), 15);
    chk("reset_busy", int'(busy), 0);
    run(407, 20'h407EF, 4);
    run(0, 20'h0EFFF, 2);
    run(9999, 20'h9999E, 5);
    @(negedge clk); start = 1; value = 14'd10000;
    @(negedge clk); start = 0;
    chk("err_pulse", int'(err), 1);
    chk("err_busy", int'(busy), 0);
    @(negedge clk);
    chk("err_once", int'(err), 0);
    chk("err_busy2", int'(busy), 0);
    // abort during the second key press
    clr();
    @(negedge clk); start = 1; value = 14'd56;
    @(negedge clk); start = 0;
    for (int t = 0; t < 100 && obs.size() < 2; t++) @(negedge clk);
    chk("abort_reach", obs.size(), 2);
    abort = 1;
    @(negedge clk); abort = 0;
    chk("abort_kw", int'(keyword), 15);
    chk("abort_fp", int'(flag_pressed), 0);
    chk("abort_busy", int'(busy), 0);
    repeat (10) @(negedge clk);
    chk("abort_nodone", done_cnt, 0);
    run(3, 20'h3EFFF, 2);
    // reset in the middle of the first gap
    clr();
    @(negedge clk); start = 1; value = 14'd407;
    @(negedge clk); start = 0;
    for (int t = 0; t < 100 && !(obs.size() == 1 && flag_pressed == 2'b00); t++) @(negedge clk);
    chk("gap_reach", obs.size(), 1);
    rst = 1;
    @(negedge clk); rst = 0;
    chk("rst_outs", int'({keyword, flag_pressed, busy, done, err}), int'({4'hF, 2'b00, 3'b000}));
    repeat (5) @(negedge clk);
    chk("rst_noresume", int'(busy), 0);
    // start held high for the whole sequence, including the FIN cycle
    clr();
    start = 1; value = 14'd5;
    for (int t = 0; t < 200 && !done; t++) @(negedge clk);
    chk("held_done", int'(done), 1);
    start = 0;
    repeat (4) @(negedge clk);
    chk("held_keys", obs.size(), 2);
    chk("held_done_cnt", done_cnt, 1);
    chk("held_idle", int'(busy), 0);
    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst = ($urandom % 500) == 0;
      abort = ($urandom % 200) == 0;
      start = ($urandom % 6) == 0;
      case ($urandom % 4)
        0: value = 14'($urandom_range(10000, 16383));
        1: value = 14'($urandom_range(0, 99));
        default: value = 14'($urandom_range(0, 9999));
      endcase
    end
    @(negedge clk); rst = 0; abort = 0; start = 0;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
